// File: rtl/write_arbiter.sv
// AXI write-address arbiter: round-robin across three masters, grant locked
// from AW handshake until the decoder's done pulse, payload held while locked.
module write_arbiter (
  input  logic        clk,
  input  logic        rst,
  input  logic        AWVALID_M0,
  input  logic [31:0] AWADDR_M0,
  input  logic [3:0]  AWID_M0,
  input  logic [3:0]  AWLEN_M0,
  input  logic [2:0]  AWSIZE_M0,
  input  logic [1:0]  AWBURST_M0,
  input  logic        AWVALID_M1,
  input  logic [31:0] AWADDR_M1,
  input  logic [3:0]  AWID_M1,
  input  logic [3:0]  AWLEN_M1,
  input  logic [2:0]  AWSIZE_M1,
  input  logic [1:0]  AWBURST_M1,
  input  logic        AWVALID_M2,
  input  logic [31:0] AWADDR_M2,
  input  logic [3:0]  AWID_M2,
  input  logic [3:0]  AWLEN_M2,
  input  logic [2:0]  AWSIZE_M2,
  input  logic [1:0]  AWBURST_M2,
  output logic        AWREADY_M0,
  output logic        AWREADY_M1,
  output logic        AWREADY_M2,
  output logic        AWVALID,
  output logic [31:0] AWADDR,
  output logic [7:0]  AWID_S,
  output logic [3:0]  AWLEN,
  output logic [2:0]  AWSIZE,
  output logic [1:0]  AWBURST,
  input  logic        AWREADY,
  input  logic        done,
  output logic [1:0]  WMASTER_Src,
  output logic        busy,
  output logic [1:0]  dbg_state_o
);

  // Handshake: an AW transfer happens in a cycle where AWVALID and AWREADY
  // are both high; AWREADY_M[grant] mirrors AWREADY combinationally in ADDR.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_LOCK = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [1:0]  grant_q, grant_d;
  logic [1:0]  last_grant_q, last_grant_d;
  logic [31:0] hold_addr_q, hold_addr_d;
  logic [3:0]  hold_id_q, hold_id_d;
  logic [3:0]  hold_len_q, hold_len_d;
  logic [2:0]  hold_size_q, hold_size_d;
  logic [1:0]  hold_burst_q, hold_burst_d;

  logic [2:0]  req_vec;
  logic [1:0]  cand_1, cand_2, cand_3;
  logic [1:0]  pick;
  logic        req_any;

  logic        sel_valid;
  logic [31:0] sel_addr;
  logic [3:0]  sel_id;
  logic [3:0]  sel_len;
  logic [2:0]  sel_size;
  logic [1:0]  sel_burst;

  assign req_vec = {AWVALID_M2, AWVALID_M1, AWVALID_M0};
  assign req_any = |req_vec;

  function automatic logic [1:0] rr_next(input logic [1:0] idx);
    return (idx >= 2'd2) ? 2'd0 : idx + 2'd1;
  endfunction

  function automatic logic req_at(input logic [2:0] req, input logic [1:0] idx);
    logic r;
    case (idx)
      2'd0:    r = req[0];
      2'd1:    r = req[1];
      default: r = req[2];
    endcase
    return r;
  endfunction

  // Rotating priority starts just after the last master served.
  assign cand_1 = rr_next(last_grant_q);
  assign cand_2 = rr_next(cand_1);
  assign cand_3 = rr_next(cand_2);

  always_comb begin
    pick = cand_3;
    if (req_at(req_vec, cand_1)) begin
      pick = cand_1;
    end else if (req_at(req_vec, cand_2)) begin
      pick = cand_2;
    end
  end

  always_comb begin
    sel_valid = AWVALID_M0;
    sel_addr  = AWADDR_M0;
    sel_id    = AWID_M0;
    sel_len   = AWLEN_M0;
    sel_size  = AWSIZE_M0;
    sel_burst = AWBURST_M0;
    case (grant_q)
      2'd1: begin
        sel_valid = AWVALID_M1;
        sel_addr  = AWADDR_M1;
        sel_id    = AWID_M1;
        sel_len   = AWLEN_M1;
        sel_size  = AWSIZE_M1;
        sel_burst = AWBURST_M1;
      end
      2'd2: begin
        sel_valid = AWVALID_M2;
        sel_addr  = AWADDR_M2;
        sel_id    = AWID_M2;
        sel_len   = AWLEN_M2;
        sel_size  = AWSIZE_M2;
        sel_burst = AWBURST_M2;
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    hold_addr_d  = hold_addr_q;
    hold_id_d    = hold_id_q;
    hold_len_d   = hold_len_q;
    hold_size_d  = hold_size_q;
    hold_burst_d = hold_burst_q;
    case (state_q)
      ST_IDLE: begin
        if (req_any) begin
          grant_d = pick;
          state_d = ST_ADDR;
        end
      end
      ST_ADDR: begin
        // A master that withdraws AWVALID keeps the grant; no re-arbitration.
        if (sel_valid && AWREADY) begin
          hold_addr_d  = sel_addr;
          hold_id_d    = sel_id;
          hold_len_d   = sel_len;
          hold_size_d  = sel_size;
          hold_burst_d = sel_burst;
          state_d      = ST_LOCK;
        end
      end
      ST_LOCK: begin
        if (done) begin
          last_grant_d = grant_q;
          state_d      = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    AWVALID     = 1'b0;
    AWADDR      = 32'd0;
    AWID_S      = 8'd0;
    AWLEN       = 4'd0;
    AWSIZE      = 3'd0;
    AWBURST     = 2'd0;
    AWREADY_M0  = 1'b0;
    AWREADY_M1  = 1'b0;
    AWREADY_M2  = 1'b0;
    WMASTER_Src = 2'd3;
    busy        = 1'b0;
    case (state_q)
      ST_ADDR: begin
        AWVALID     = sel_valid;
        AWADDR      = sel_addr;
        AWID_S      = {2'b00, grant_q, sel_id};
        AWLEN       = sel_len;
        AWSIZE      = sel_size;
        AWBURST     = sel_burst;
        AWREADY_M0  = (grant_q == 2'd0) && AWREADY;
        AWREADY_M1  = (grant_q == 2'd1) && AWREADY;
        AWREADY_M2  = (grant_q == 2'd2) && AWREADY;
        WMASTER_Src = grant_q;
        busy        = 1'b1;
      end
      ST_LOCK: begin
        AWADDR      = hold_addr_q;
        AWID_S      = {2'b00, grant_q, hold_id_q};
        AWLEN       = hold_len_q;
        AWSIZE      = hold_size_q;
        AWBURST     = hold_burst_q;
        WMASTER_Src = grant_q;
        busy        = 1'b1;
      end
      default: ;
    endcase
  end

  assign dbg_state_o = state_q;

  // last_grant resets to M2 so that M0 holds first priority out of reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      grant_q      <= 2'd0;
      last_grant_q <= 2'd2;
      hold_addr_q  <= 32'd0;
      hold_id_q    <= 4'd0;
      hold_len_q   <= 4'd0;
      hold_size_q  <= 3'd0;
      hold_burst_q <= 2'd0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      hold_addr_q  <= hold_addr_d;
      hold_id_q    <= hold_id_d;
      hold_len_q   <= hold_len_d;
      hold_size_q  <= hold_size_d;
      hold_burst_q <= hold_burst_d;
    end
  end

endmodule

// File: tb/tb_write_arbiter.sv
// Bench for write_arbiter: vector table, directed corner sequences and
// randomized traffic against a transaction-level reference model.
module tb_write_arbiter;

  logic        clk;
  logic        rst;
  logic [2:0]  v;
  logic [31:0] addr [3];
  logic [3:0]  id [3];
  logic [3:0]  len [3];
  logic [2:0]  size [3];
  logic [1:0]  burst [3];
  logic        ardy;
  logic        dn;

  logic        AWREADY_M0, AWREADY_M1, AWREADY_M2;
  logic        AWVALID;
  logic [31:0] AWADDR;
  logic [7:0]  AWID_S;
  logic [3:0]  AWLEN;
  logic [2:0]  AWSIZE;
  logic [1:0]  AWBURST;
  logic [1:0]  WMASTER_Src;
  logic        busy;
  logic [1:0]  dbg_state;

  write_arbiter dut (
    .clk(clk), .rst(rst),
    .AWVALID_M0(v[0]), .AWADDR_M0(addr[0]), .AWID_M0(id[0]), .AWLEN_M0(len[0]),
    .AWSIZE_M0(size[0]), .AWBURST_M0(burst[0]),
    .AWVALID_M1(v[1]), .AWADDR_M1(addr[1]), .AWID_M1(id[1]), .AWLEN_M1(len[1]),
    .AWSIZE_M1(size[1]), .AWBURST_M1(burst[1]),
    .AWVALID_M2(v[2]), .AWADDR_M2(addr[2]), .AWID_M2(id[2]), .AWLEN_M2(len[2]),
    .AWSIZE_M2(size[2]), .AWBURST_M2(burst[2]),
    .AWREADY_M0(AWREADY_M0), .AWREADY_M1(AWREADY_M1), .AWREADY_M2(AWREADY_M2),
    .AWVALID(AWVALID), .AWADDR(AWADDR), .AWID_S(AWID_S), .AWLEN(AWLEN),
    .AWSIZE(AWSIZE), .AWBURST(AWBURST), .AWREADY(ardy), .done(dn),
    .WMASTER_Src(WMASTER_Src), .busy(busy), .dbg_state_o(dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // ---------------- reference model ----------------
  int          m_owner;   // -1 when no master owns the channel
  bit          m_acc;     // address phase of the owner already accepted
  int          m_last;
  logic [31:0] h_addr;
  logic [3:0]  h_id, h_len;
  logic [2:0]  h_size;
  logic [1:0]  h_burst;
  logic [1:0]  exp_q[$];
  logic [1:0]  prev_src;

  task automatic model_reset();
    m_owner = -1;
    m_acc   = 1'b0;
    m_last  = 2;
    h_addr  = '0; h_id = '0; h_len = '0; h_size = '0; h_burst = '0;
    exp_q.delete();
  endtask

  task automatic model_update();
    bit found;
    found = 1'b0;
    if (m_owner < 0) begin
      for (int k = 1; k <= 3; k++) begin
        int idx;
        idx = (m_last + k) % 3;
        if (!found && v[idx]) begin
          found   = 1'b1;
          m_owner = idx;
          m_acc   = 1'b0;
          exp_q.push_back(2'(idx));
        end
      end
    end else if (!m_acc) begin
      if (v[m_owner] && ardy) begin
        m_acc   = 1'b1;
        h_addr  = addr[m_owner];
        h_id    = id[m_owner];
        h_len   = len[m_owner];
        h_size  = size[m_owner];
        h_burst = burst[m_owner];
      end
    end else if (dn) begin
      m_last  = m_owner;
      m_owner = -1;
      m_acc   = 1'b0;
    end
  endtask

  function automatic logic [57:0] model_exp();
    logic [2:0] r;
    logic [1:0] o;
    r = 3'b000;
    if (m_owner < 0)
      return {1'b0, 2'd3, 1'b0, 3'b000, 32'd0, 8'd0, 4'd0, 3'd0, 2'd0, 2'd0};
    o = 2'(m_owner);
    if (!m_acc) begin
      r[m_owner] = ardy;
      return {1'b1, o, v[m_owner], r, addr[m_owner], {2'b00, o, id[m_owner]},
              len[m_owner], size[m_owner], burst[m_owner], 2'd1};
    end
    return {1'b1, o, 1'b0, 3'b000, h_addr, {2'b00, o, h_id}, h_len, h_size, h_burst, 2'd2};
  endfunction

  function automatic logic [57:0] act_vec();
    return {busy, WMASTER_Src, AWVALID, AWREADY_M2, AWREADY_M1, AWREADY_M0,
            AWADDR, AWID_S, AWLEN, AWSIZE, AWBURST, dbg_state};
  endfunction

  // ---------------- scoreboard ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Inputs change at posedge+1; the model is compared at posedge+7.
  task automatic tick();
    #4;
    check("model", 64'(act_vec()), 64'(model_exp()));
    @(posedge clk);
    if (rst) model_reset();
    else model_update();
    #1;
    if (prev_src == 2'd3 && WMASTER_Src != 2'd3) begin
      if (exp_q.size() == 0) begin
        check("grant_unexpected", 64'(WMASTER_Src), 64'd3);
      end else begin
        logic [1:0] eg;
        eg = exp_q.pop_front();
        check("grant_order", 64'(WMASTER_Src), 64'(eg));
      end
    end
    prev_src = WMASTER_Src;
  endtask

  task automatic clear_inputs();
    v = 3'b000; ardy = 1'b0; dn = 1'b0;
    for (int i = 0; i < 3; i++) begin
      addr[i]  = 32'h1000_0000 * (i + 1) + 32'h40;
      id[i]    = 4'(i + 3);
      len[i]   = 4'(i + 1);
      size[i]  = 3'd2;
      burst[i] = 2'd1;
    end
  endtask

  task automatic reset_dut();
    rst = 1'b1;
    model_reset();
    clear_inputs();
    tick();
    tick();
    rst = 1'b0;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [2:0] v;
    logic       ardy;
    logic       dn;
    logic [1:0] st;
    logic [1:0] src;
    logic       av;
    logic [2:0] rdy;
    logic       busy;
  } vec_t;

  vec_t tbl[17];

  initial begin
    tbl[0]  = '{3'b010, 1'b1, 1'b0, 2'd0, 2'd3, 1'b0, 3'b000, 1'b0};
    tbl[1]  = '{3'b010, 1'b1, 1'b0, 2'd1, 2'd1, 1'b1, 3'b010, 1'b1};
    tbl[2]  = '{3'b010, 1'b1, 1'b0, 2'd2, 2'd1, 1'b0, 3'b000, 1'b1};
    tbl[3]  = '{3'b011, 1'b0, 1'b0, 2'd2, 2'd1, 1'b0, 3'b000, 1'b1};
    tbl[4]  = '{3'b001, 1'b0, 1'b1, 2'd2, 2'd1, 1'b0, 3'b000, 1'b1};
    tbl[5]  = '{3'b001, 1'b0, 1'b0, 2'd0, 2'd3, 1'b0, 3'b000, 1'b0};
    tbl[6]  = '{3'b001, 1'b0, 1'b0, 2'd1, 2'd0, 1'b1, 3'b000, 1'b1};
    tbl[7]  = '{3'b000, 1'b1, 1'b0, 2'd1, 2'd0, 1'b0, 3'b001, 1'b1};
    tbl[8]  = '{3'b001, 1'b1, 1'b0, 2'd1, 2'd0, 1'b1, 3'b001, 1'b1};
    tbl[9]  = '{3'b000, 1'b0, 1'b0, 2'd2, 2'd0, 1'b0, 3'b000, 1'b1};
    tbl[10] = '{3'b000, 1'b0, 1'b1, 2'd2, 2'd0, 1'b0, 3'b000, 1'b1};
    tbl[11] = '{3'b000, 1'b0, 1'b1, 2'd0, 2'd3, 1'b0, 3'b000, 1'b0};
    tbl[12] = '{3'b111, 1'b0, 1'b0, 2'd0, 2'd3, 1'b0, 3'b000, 1'b0};
    tbl[13] = '{3'b111, 1'b0, 1'b0, 2'd1, 2'd1, 1'b1, 3'b000, 1'b1};
    tbl[14] = '{3'b111, 1'b1, 1'b0, 2'd1, 2'd1, 1'b1, 3'b010, 1'b1};
    tbl[15] = '{3'b000, 1'b0, 1'b1, 2'd2, 2'd1, 1'b0, 3'b000, 1'b1};
    tbl[16] = '{3'b000, 1'b0, 1'b0, 2'd0, 2'd3, 1'b0, 3'b000, 1'b0};
  end

  // ---------------- test sequence ----------------
  initial begin
    logic [1:0] rr_exp [4];
    rr_exp[0] = 2'd0; rr_exp[1] = 2'd1; rr_exp[2] = 2'd2; rr_exp[3] = 2'd0;
    prev_src = 2'd3;
    reset_dut();

    // Reset state
    #2;
    check("rst_state", 64'(dbg_state), 64'd0);
    check("rst_src", 64'(WMASTER_Src), 64'd3);
    check("rst_busy_valid_rdy", 64'({busy, AWVALID, AWREADY_M2, AWREADY_M1, AWREADY_M0}), 64'd0);
    tick();

    // Single request from M1 with address hold in LOCK
    addr[1] = 32'h0002_0010; id[1] = 4'd5; v = 3'b010; ardy = 1'b1;
    #2;
    check("single_idle_valid", 64'(AWVALID), 64'd0);
    tick();
    #2;
    check("single_awvalid", 64'(AWVALID), 64'd1);
    check("single_awready_m1", 64'(AWREADY_M1), 64'd1);
    check("single_awid_s", 64'(AWID_S), 64'h15);
    check("single_src", 64'(WMASTER_Src), 64'd1);
    check("single_addr", 64'(AWADDR), 64'h0002_0010);
    tick();
    addr[1] = 32'hFFFF_FFFF; v = 3'b000;
    #2;
    check("single_lock_state", 64'(dbg_state), 64'd2);
    check("single_lock_addr", 64'(AWADDR), 64'h0002_0010);
    check("single_lock_id", 64'(AWID_S), 64'h15);
    tick();
    dn = 1'b1; tick(); dn = 1'b0; tick();

    // Vector table, started from a fresh reset (M0 first priority)
    reset_dut();
    for (int i = 0; i < 17; i++) begin
      v = tbl[i].v; ardy = tbl[i].ardy; dn = tbl[i].dn;
      #2;
      check($sformatf("tbl[%0d]", i),
            64'({dbg_state, WMASTER_Src, AWVALID, AWREADY_M2, AWREADY_M1, AWREADY_M0, busy}),
            64'({tbl[i].st, tbl[i].src, tbl[i].av, tbl[i].rdy, tbl[i].busy}));
      tick();
    end

    // Round robin with done after every grant; two-cycle turnaround
    reset_dut();
    v = 3'b111; ardy = 1'b1;
    tick();
    for (int g = 0; g < 4; g++) begin
      #2;
      check($sformatf("rr_grant[%0d]", g), 64'({dbg_state, WMASTER_Src}), 64'({2'd1, rr_exp[g]}));
      tick();
      dn = 1'b1;
      #2;
      check($sformatf("rr_lock[%0d]", g), 64'(dbg_state), 64'd2);
      tick();
      dn = 1'b0;
      #2;
      check($sformatf("rr_idle[%0d]", g), 64'(dbg_state), 64'd0);
      tick();
    end
    v = 3'b000;
    tick();

    // Decoder back-pressure with M2 granted
    reset_dut();
    v = 3'b100; ardy = 1'b0;
    tick();
    for (int c = 0; c < 4; c++) begin
      #2;
      check($sformatf("bp_hold[%0d]", c), 64'({AWVALID, dbg_state, AWREADY_M2}), 64'({1'b1, 2'd1, 1'b0}));
      tick();
    end
    ardy = 1'b1;
    #2;
    check("bp_handshake", 64'({AWVALID, AWREADY_M2}), 64'b11);
    tick();
    ardy = 1'b0; v = 3'b000;
    #2;
    check("bp_lock", 64'(dbg_state), 64'd2);
    tick();
    dn = 1'b1; tick(); dn = 1'b0; tick();

    // Lock hold: M1 requests while M0 owns the channel
    reset_dut();
    v = 3'b001; ardy = 1'b1;
    tick(); tick();
    v = 3'b010; ardy = 1'b0;
    for (int c = 0; c < 10; c++) begin
      #2;
      check($sformatf("lock_hold[%0d]", c), 64'({AWREADY_M1, AWVALID, dbg_state}), 64'({1'b0, 1'b0, 2'd2}));
      tick();
    end
    dn = 1'b1; tick(); dn = 1'b0;
    tick();
    #2;
    check("lock_next_grant", 64'({dbg_state, WMASTER_Src}), 64'({2'd1, 2'd1}));
    tick();
    v = 3'b000; ardy = 1'b1; tick(); ardy = 1'b0;
    dn = 1'b1; tick(); dn = 1'b0; tick();

    // Asynchronous reset while M2 is in LOCK
    reset_dut();
    v = 3'b100; ardy = 1'b1;
    tick(); tick();
    v = 3'b000; ardy = 1'b0;
    #2;
    check("mid_lock_pre", 64'({dbg_state, WMASTER_Src}), 64'({2'd2, 2'd2}));
    rst = 1'b1;
    model_reset();
    #1;
    check("mid_rst_outputs", 64'({busy, WMASTER_Src, AWVALID, AWADDR, dbg_state}),
          64'({1'b0, 2'd3, 1'b0, 32'd0, 2'd0}));
    v = 3'b101;
    tick();
    rst = 1'b0;
    tick();
    #2;
    check("post_rst_grant", 64'({dbg_state, WMASTER_Src}), 64'({2'd1, 2'd0}));
    tick();

    // Randomized traffic against the reference model
    reset_dut();
    for (int n = 0; n < 3000; n++) begin
      rst = ($urandom_range(0, 299) == 0);
      if (rst) model_reset();
      for (int i = 0; i < 3; i++) begin
        v[i] = ($urandom_range(0, 99) < 55);
        if ($urandom_range(0, 3) == 0) begin
          addr[i]  = $urandom;
          id[i]    = 4'($urandom_range(0, 15));
          len[i]   = 4'($urandom_range(0, 15));
          size[i]  = 3'($urandom_range(0, 7));
          burst[i] = 2'($urandom_range(0, 3));
        end
      end
      ardy = 1'($urandom_range(0, 1));
      dn   = ($urandom_range(0, 3) == 0);
      tick();
    end
    rst = 1'b0;
    clear_inputs();
    tick();
    check("grant_queue_drained", 64'(exp_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
